// File: rtl/mips_alu_issue_ctrl.sv
// Issue/decode front-end for the 32-bit MIPS ALU: accepts one instruction, drives the
// ALU for SETTLE_CYCLES, captures result/Zero and returns them with a branch decision.
module mips_alu_issue_ctrl #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic             res_branch_taken,
    output logic             res_illegal
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_EQ   = 2'd1,
        BR_NE   = 2'd2
    } br_t;

    state_t           state_q, state_d;
    br_t              br_q;
    logic [CNT_W-1:0] cnt_q;

    logic [3:0]       dec_ctrl_c;
    logic             dec_legal_c;
    br_t              dec_br_c;
    logic             accept_c;
    logic             capture_c;

    // Decode opcode/funct into ALU control code, legality and branch kind
    always_comb begin
        dec_ctrl_c  = 4'b0000;
        dec_legal_c = 1'b1;
        dec_br_c    = BR_NONE;
        if (opcode == 6'h00) begin
            case (funct)
                6'h20, 6'h21: dec_ctrl_c = 4'b0010;
                6'h22, 6'h23: dec_ctrl_c = 4'b0110;
                6'h24:        dec_ctrl_c = 4'b0000;
                6'h25:        dec_ctrl_c = 4'b0001;
                6'h27:        dec_ctrl_c = 4'b1100;
                6'h2A:        dec_ctrl_c = 4'b0111;
                default:      dec_legal_c = 1'b0;
            endcase
        end else begin
            case (opcode)
                6'h08, 6'h23, 6'h2B: dec_ctrl_c = 4'b0010;
                6'h0C:               dec_ctrl_c = 4'b0000;
                6'h0D:               dec_ctrl_c = 4'b0001;
                6'h0A:               dec_ctrl_c = 4'b0111;
                6'h04: begin
                    dec_ctrl_c = 4'b0110;
                    dec_br_c   = BR_EQ;
                end
                6'h05: begin
                    dec_ctrl_c = 4'b0110;
                    dec_br_c   = BR_NE;
                end
                default: dec_legal_c = 1'b0;
            endcase
        end
    end

    // Next-state logic and per-edge action strobes
    always_comb begin
        state_d   = state_q;
        accept_c  = 1'b0;
        capture_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    accept_c = 1'b1;
                    state_d  = dec_legal_c ? S_EXEC : S_DONE;
                end
            end
            S_EXEC: begin
                // <= 1 rather than == 1 so an out-of-range setting cannot wedge the FSM
                if (cnt_q <= CNT_W'(1)) begin
                    capture_c = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with registered handshake outputs derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            in_ready  <= 1'b1;
            res_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == S_IDLE);
            res_valid <= (state_d == S_DONE);
        end
    end

    // Settle counter: loaded on a legal accept, counts down while executing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept_c && dec_legal_c) begin
            cnt_q <= CNT_W'(SETTLE_CYCLES);
        end else if (state_q == S_EXEC && cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // ALU drive registers and branch tag, updated only on a legal accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_ctrl <= 4'b0000;
            alu_a    <= '0;
            alu_b    <= '0;
            br_q     <= BR_NONE;
        end else if (accept_c && dec_legal_c) begin
            alu_ctrl <= dec_ctrl_c;
            alu_a    <= op_a;
            alu_b    <= op_b;
            br_q     <= dec_br_c;
        end
    end

    // Result registers: cleared with illegal flag on a bad accept, loaded at capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data         <= '0;
            res_zero         <= 1'b0;
            res_branch_taken <= 1'b0;
            res_illegal      <= 1'b0;
        end else if (accept_c && !dec_legal_c) begin
            res_data         <= '0;
            res_zero         <= 1'b0;
            res_branch_taken <= 1'b0;
            res_illegal      <= 1'b1;
        end else if (capture_c) begin
            res_data         <= alu_out;
            res_zero         <= alu_zero;
            res_illegal      <= 1'b0;
            case (br_q)
                BR_EQ:   res_branch_taken <= alu_zero;
                BR_NE:   res_branch_taken <= ~alu_zero;
                default: res_branch_taken <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_alu_issue_ctrl.sv
// Directed bench for mips_alu_issue_ctrl with a behavioural ALU attached to its outputs.
module tb_mips_alu_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_zero;
    logic        res_branch_taken;
    logic        res_illegal;

    int total;
    int bad;

    mips_alu_issue_ctrl #(
        .WIDTH         (32),
        .SETTLE_CYCLES (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .opcode           (opcode),
        .funct            (funct),
        .op_a             (op_a),
        .op_b             (op_b),
        .alu_ctrl         (alu_ctrl),
        .alu_a            (alu_a),
        .alu_b            (alu_b),
        .alu_out          (alu_out),
        .alu_zero         (alu_zero),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_data         (res_data),
        .res_zero         (res_zero),
        .res_branch_taken (res_branch_taken),
        .res_illegal      (res_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural MIPS ALU driven by the DUT
    always_comb begin
        case (alu_ctrl)
            4'b0010: alu_out = alu_a + alu_b;
            4'b0110: alu_out = alu_a - alu_b;
            4'b0000: alu_out = alu_a & alu_b;
            4'b0001: alu_out = alu_a | alu_b;
            4'b1100: alu_out = ~(alu_a | alu_b);
            4'b0111: alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_out = 32'd0;
        endcase
        alu_zero = (alu_out == 32'd0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Offer one instruction; returns edges from accept (inclusive) until res_valid is seen
    task automatic offer(input string name, input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_a, input logic [31:0] exp_b, output int lat);
        check1({name, ":in_ready_idle"}, in_ready, 1'b1);
        opcode   = op;
        funct    = fn;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        opcode   = 6'h3F;
        funct    = 6'h3F;
        op_a     = 32'hDEAD_BEEF;
        op_b     = 32'hCAFE_F00D;
        check1({name, ":in_ready_busy"}, in_ready, 1'b0);
        lat = 1;
        while (res_valid !== 1'b1 && lat < 20) begin
            check({name, ":alu_a_hold"}, alu_a, exp_a);
            check({name, ":alu_b_hold"}, alu_b, exp_b);
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Full transaction with res_ready high: offer, check result, check handshake release
    task automatic run_op(input string name, input logic [5:0] op, input logic [5:0] fn,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] exp_ctrl, input logic [31:0] exp_a,
                          input logic [31:0] exp_b, input logic [31:0] exp_data,
                          input logic exp_zero, input logic exp_taken, input logic exp_ill,
                          input int exp_lat);
        int lat;
        offer(name, op, fn, a, b, exp_a, exp_b, lat);
        check({name, ":latency"}, 32'(lat), 32'(exp_lat));
        check({name, ":alu_ctrl"}, {28'd0, alu_ctrl}, {28'd0, exp_ctrl});
        check({name, ":alu_a"}, alu_a, exp_a);
        check({name, ":alu_b"}, alu_b, exp_b);
        check({name, ":res_data"}, res_data, exp_data);
        check1({name, ":res_zero"}, res_zero, exp_zero);
        check1({name, ":res_taken"}, res_branch_taken, exp_taken);
        check1({name, ":res_illegal"}, res_illegal, exp_ill);
        @(posedge clk);
        #1;
        check1({name, ":res_valid_drop"}, res_valid, 1'b0);
        check1({name, ":in_ready_back"}, in_ready, 1'b1);
    endtask

    initial begin
        int lat;
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        opcode    = 6'h00;
        funct     = 6'h00;
        op_a      = 32'd0;
        op_b      = 32'd0;
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // reset state
        check1("rst:in_ready", in_ready, 1'b1);
        check1("rst:res_valid", res_valid, 1'b0);
        check("rst:alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
        check("rst:alu_a", alu_a, 32'd0);
        check("rst:alu_b", alu_b, 32'd0);
        check("rst:res_data", res_data, 32'd0);
        check1("rst:res_zero", res_zero, 1'b0);
        check1("rst:res_taken", res_branch_taken, 1'b0);
        check1("rst:res_illegal", res_illegal, 1'b0);

        // settle = 2 -> legal result seen 3 edges after accept, illegal 1 edge
        run_op("add", 6'h00, 6'h20, 32'h19, 32'h3D, 4'b0010, 32'h19, 32'h3D, 32'h56, 1'b0, 1'b0, 1'b0, 3);
        run_op("sub", 6'h00, 6'h22, 32'h0, 32'h1, 4'b0110, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 3);
        run_op("beq", 6'h04, 6'h00, 32'h1234, 32'h1234, 4'b0110, 32'h1234, 32'h1234, 32'h0, 1'b1, 1'b1, 1'b0, 3);
        run_op("ill_op", 6'h3F, 6'h20, 32'h5, 32'h6, 4'b0110, 32'h1234, 32'h1234, 32'h0, 1'b0, 1'b0, 1'b1, 1);
        run_op("bne_eq", 6'h05, 6'h00, 32'h1234, 32'h1234, 4'b0110, 32'h1234, 32'h1234, 32'h0, 1'b1, 1'b0, 1'b0, 3);
        run_op("bne_ne", 6'h05, 6'h00, 32'h1, 32'h2, 4'b0110, 32'h1, 32'h2, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 3);
        run_op("slt", 6'h00, 6'h2A, 32'h0, 32'h9, 4'b0111, 32'h0, 32'h9, 32'h1, 1'b0, 1'b0, 1'b0, 3);
        run_op("nor", 6'h00, 6'h27, 32'h19, 32'h3D, 4'b1100, 32'h19, 32'h3D, 32'hFFFF_FFC2, 1'b0, 1'b0, 1'b0, 3);
        run_op("ill_fn", 6'h00, 6'h18, 32'h7, 32'h8, 4'b1100, 32'h19, 32'h3D, 32'h0, 1'b0, 1'b0, 1'b1, 1);
        run_op("ori", 6'h0D, 6'h00, 32'hF0, 32'h0F, 4'b0001, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0, 1'b0, 3);
        run_op("andi", 6'h0C, 6'h00, 32'hF0, 32'h3C, 4'b0000, 32'hF0, 32'h3C, 32'h30, 1'b0, 1'b0, 1'b0, 3);
        run_op("lw", 6'h23, 6'h00, 32'h1000, 32'hFFFF_FFFC, 4'b0010, 32'h1000, 32'hFFFF_FFFC, 32'h0FFC, 1'b0, 1'b0, 1'b0, 3);
        run_op("slti", 6'h0A, 6'h00, 32'hFFFF_FFFF, 32'h1, 4'b0111, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0, 3);
        run_op("sw", 6'h2B, 6'h00, 32'h4, 32'hFFFF_FFFC, 4'b0010, 32'h4, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0, 1'b0, 3);
        run_op("addi", 6'h08, 6'h00, 32'h10, 32'h22, 4'b0010, 32'h10, 32'h22, 32'h32, 1'b0, 1'b0, 1'b0, 3);
        run_op("subu", 6'h00, 6'h23, 32'h5, 32'h5, 4'b0110, 32'h5, 32'h5, 32'h0, 1'b1, 1'b0, 1'b0, 3);
        run_op("and", 6'h00, 6'h24, 32'hFF00, 32'h0FF0, 4'b0000, 32'hFF00, 32'h0FF0, 32'h0F00, 1'b0, 1'b0, 1'b0, 3);
        run_op("or", 6'h00, 6'h25, 32'hFF00, 32'h0FF0, 4'b0001, 32'hFF00, 32'h0FF0, 32'hFFF0, 1'b0, 1'b0, 1'b0, 3);
        run_op("addu", 6'h00, 6'h21, 32'hFFFF_FFFF, 32'h1, 4'b0010, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1'b0, 3);

        // backpressure: result held for 3 cycles, new offer ignored while busy
        res_ready = 1'b0;
        offer("bp", 6'h00, 6'h20, 32'h2, 32'h3, 32'h2, 32'h3, lat);
        check("bp:latency", 32'(lat), 32'd3);
        opcode   = 6'h00;
        funct    = 6'h22;
        op_a     = 32'h100;
        op_b     = 32'h1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check1("bp:res_valid", res_valid, 1'b1);
            check("bp:res_data", res_data, 32'h5);
            check1("bp:res_zero", res_zero, 1'b0);
            check1("bp:res_illegal", res_illegal, 1'b0);
            check1("bp:in_ready", in_ready, 1'b0);
            check("bp:alu_a", alu_a, 32'h2);
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        check1("bp:res_valid_drop", res_valid, 1'b0);
        check1("bp:in_ready_back", in_ready, 1'b1);
        check("bp:alu_ctrl_kept", {28'd0, alu_ctrl}, 32'h2);

        // reset during EXEC drops the op; next op completes normally
        opcode   = 6'h00;
        funct    = 6'h27;
        op_a     = 32'hAA;
        op_b     = 32'h55;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check1("mr:in_exec", in_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check1("mr:in_ready", in_ready, 1'b1);
        check1("mr:res_valid", res_valid, 1'b0);
        check("mr:alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
        check("mr:alu_a", alu_a, 32'd0);
        check("mr:alu_b", alu_b, 32'd0);
        check("mr:res_data", res_data, 32'd0);
        check1("mr:res_zero", res_zero, 1'b0);
        check1("mr:res_taken", res_branch_taken, 1'b0);
        check1("mr:res_illegal", res_illegal, 1'b0);
        @(posedge clk);
        #1;
        check1("mr:held_valid", res_valid, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check1("mr:no_replay", res_valid, 1'b0);
        run_op("post_rst", 6'h00, 6'h20, 32'h7, 32'h8, 4'b0010, 32'h7, 32'h8, 32'hF, 1'b0, 1'b0, 1'b0, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
